// File: rtl/present_la_engine_if.sv
// Command/readback bus between LA-facing firmware glue and the PRESENT engine.
// Ports: cmd_stb/cmd_op/cmd_addr/cmd_data (firmware -> engine),
//        rd_data/busy/done (engine -> firmware). DW sets data word width.
interface present_la_engine_if #(
    parameter int DW = 32
);
    logic          cmd_stb;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;

    modport master (
        output cmd_stb, cmd_op, cmd_addr, cmd_data,
        input  rd_data, busy, done
    );

    modport slave (
        input  cmd_stb, cmd_op, cmd_addr, cmd_data,
        output rd_data, busy, done
    );
endinterface

// File: rtl/present_la_engine.sv
// Round-iterative PRESENT-64 encryptor (80/128-bit key) behind a strobe-driven
// command bus. Ports: wb_clk_i, wb_rst_i (sync, active-high), bus (slave modport).
// One round per cycle: busy for 32 cycles after start, done sticky until op 3.
module present_la_engine #(
    parameter int KEY_BITS = 80,
    parameter int DW       = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    present_la_engine_if.slave bus
);
    localparam int NPW = 64 / DW;
    localparam int NKW = (KEY_BITS + DW - 1) / DW;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_SEL   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic [63:0]         pt;
    logic [KEY_BITS-1:0] key;
    logic [63:0]         state;
    logic [KEY_BITS-1:0] kreg;
    logic [KEY_BITS-1:0] key_nxt;
    logic [63:0]         ct;
    logic [63:0]         rk;
    logic [3:0]          rd_sel;
    logic [5:0]          rc;
    logic                stb_q;
    logic                busy_q;
    logic                done_q;
    logic [DW-1:0]       rd_q;
    logic [DW-1:0]       rd_nxt;
    logic                ev;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        for (int n = 0; n < 16; n++) s_layer[4*n +: 4] = sbox(x[4*n +: 4]);
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        for (int i = 0; i < 63; i++) p_layer[(16*i) % 63] = x[i];
        p_layer[63] = x[63];
    endfunction

    assign ev = bus.cmd_stb & ~stb_q;
    assign rk = kreg[KEY_BITS-1 -: 64];

    // Key schedule: rotate left 61 (== right by KEY_BITS-61), S-box the top
    // nibble(s), fold the 5-bit round counter into the fixed bit window.
    generate
        if (KEY_BITS == 80) begin : g_k80
            logic [79:0] rot;
            assign rot = {kreg[18:0], kreg[79:19]};
            always_comb begin
                key_nxt         = rot;
                key_nxt[79:76]  = sbox(rot[79:76]);
                key_nxt[19:15]  = rot[19:15] ^ rc[4:0];
            end
        end else begin : g_k128
            logic [127:0] rot;
            assign rot = {kreg[66:0], kreg[127:67]};
            always_comb begin
                key_nxt           = rot;
                key_nxt[127:124]  = sbox(rot[127:124]);
                key_nxt[123:120]  = sbox(rot[123:120]);
                key_nxt[66:62]    = rot[66:62] ^ rc[4:0];
            end
        end
    endgenerate

    // Words beyond the ciphertext width read back as zero.
    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i < NPW; i++) begin
            if (rd_sel == 4'(i)) rd_nxt = ct[i*DW +: DW];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pt     <= '0;
            key    <= '0;
            state  <= '0;
            kreg   <= '0;
            ct     <= '0;
            rd_sel <= '0;
            rc     <= '0;
            stb_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            stb_q <= bus.cmd_stb;
            rd_q  <= rd_nxt;

            if (busy_q) begin
                if (rc == 6'd32) begin
                    ct     <= state ^ rk;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state <= p_layer(s_layer(state ^ rk));
                    kreg  <= key_nxt;
                    rc    <= rc + 6'd1;
                end
            end

            if (ev) begin
                case (bus.cmd_op)
                    OP_WRITE: if (!busy_q) begin
                        for (int i = 0; i < NPW; i++) begin
                            if (bus.cmd_addr == 5'(i)) pt[i*DW +: DW] <= bus.cmd_data;
                        end
                        // Bit-wise so the unused MSBs of the top key word are dropped.
                        for (int b = 0; b < KEY_BITS; b++) begin
                            if (bus.cmd_addr == 5'(16 + b / DW)) key[b] <= bus.cmd_data[b % DW];
                        end
                    end
                    OP_START: if (!busy_q) begin
                        state  <= pt;
                        kreg   <= key;
                        rc     <= 6'd1;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                    end
                    OP_SEL:   rd_sel <= bus.cmd_addr[3:0];
                    OP_CLEAR: if (!busy_q) done_q <= 1'b0;
                    default:  ;
                endcase
            end
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Width sanity for NKW is implicit in the key-write address decode.
    localparam int NKW_CHECK_UNUSED = NKW;
endmodule
